// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared display-side source indices, scheduler state encoding and pattern defaults
package seg_display_pkg;
  localparam int SRC_ALERT = 0;
  localparam int SRC_PRI = 1;
  localparam int SRC_SEC = 2;
  localparam logic [31:0] IDLE_PATTERN_DEF = 32'h0000_0000;
  localparam logic [31:0] BLINK_FILL_DEF = 32'hBBBB_BBBB;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_OPEN} state_t;
endpackage

// File: rtl/seven_segment_display_scheduler_if.sv
// seven_segment_display_scheduler_if: requester bundle (req/data/dp/blink_en in) and driver words (grant/display_data/dot_point/tick out)
interface seven_segment_display_scheduler_if;
  logic [2:0] req;
  logic [2:0] blink_en;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [7:0] dp0;
  logic [7:0] dp1;
  logic [7:0] dp2;
  logic [2:0] grant;
  logic [31:0] display_data;
  logic [7:0] dot_point;
  logic tick;
  modport master(output req, blink_en, data0, data1, data2, dp0, dp1, dp2, input grant, display_data, dot_point, tick);
  modport slave(input req, blink_en, data0, data1, data2, dp0, dp1, dp2, output grant, display_data, dot_point, tick);
endinterface

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: free-running divider; clk/rst in, tick out as a registered one-cycle pulse every TICK_DIV cycles
module seg_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [15:0] cnt;
  logic wrap;
  assign wrap = cnt == 16'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 16'd1;
      tick <= wrap;
    end
  end
endmodule

// File: rtl/seven_segment_display_scheduler.sv
// seven_segment_display_scheduler: alert-priority / round-robin owner of the 7-seg driver; clk, rst, bus (slave: req/data/dp/blink_en in, grant/display_data/dot_point/tick out)
module seven_segment_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int MIN_HOLD_TICKS = 500,
  parameter int BLINK_TICKS = 250,
  parameter logic [31:0] IDLE_PATTERN = IDLE_PATTERN_DEF,
  parameter logic [31:0] BLINK_FILL = BLINK_FILL_DEF
) (
  input logic clk,
  input logic rst,
  seven_segment_display_scheduler_if.slave bus
);
  state_t state, state_nxt;
  logic tick;
  logic [2:0] grant_q, arb, g_nxt;
  logic rr_ptr;
  logic [15:0] hold_cnt, blink_cnt;
  logic blink_off, off_nxt, fresh, other, blink_wrap;
  logic [31:0] disp_q, data_sel;
  logic [7:0] dp_q, dp_sel;
  seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign bus.tick = tick;
  assign bus.grant = grant_q;
  assign bus.display_data = disp_q;
  assign bus.dot_point = dp_q;
  // rr_ptr=0 favours primary, 1 favours secondary
  assign arb = bus.req[SRC_ALERT] ? 3'b001 :
               (bus.req[SRC_PRI] && bus.req[SRC_SEC]) ? (rr_ptr ? 3'b100 : 3'b010) :
               bus.req[SRC_PRI] ? 3'b010 : bus.req[SRC_SEC] ? 3'b100 : 3'b000;
  assign other = grant_q[SRC_PRI] ? bus.req[SRC_SEC] : grant_q[SRC_SEC] & bus.req[SRC_PRI];
  always_comb begin
    g_nxt = grant_q;
    state_nxt = state;
    if (state == ST_IDLE || !(|(grant_q & bus.req))) begin
      g_nxt = arb;
      state_nxt = |arb ? ST_HOLD : ST_IDLE;
    end else if (bus.req[SRC_ALERT] && !grant_q[SRC_ALERT]) begin
      g_nxt = 3'b001;
      state_nxt = ST_HOLD;
    end else if (state == ST_OPEN && other) begin
      g_nxt = {grant_q[SRC_PRI], grant_q[SRC_SEC], 1'b0};
      state_nxt = ST_HOLD;
    end else if (state == ST_HOLD && tick && hold_cnt == 16'(MIN_HOLD_TICKS - 1)) begin
      state_nxt = ST_OPEN;
    end
  end
  assign fresh = |g_nxt && g_nxt != grant_q;
  assign blink_wrap = tick && blink_cnt == 16'(BLINK_TICKS - 1);
  assign off_nxt = blink_wrap ? !blink_off : blink_off;
  // mux is driven from the next owner so grant and display words change on the same edge
  assign data_sel = g_nxt[SRC_ALERT] ? bus.data0 : g_nxt[SRC_PRI] ? bus.data1 : g_nxt[SRC_SEC] ? bus.data2 : IDLE_PATTERN;
  assign dp_sel = g_nxt[SRC_ALERT] ? bus.dp0 : g_nxt[SRC_PRI] ? bus.dp1 : g_nxt[SRC_SEC] ? bus.dp2 : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant_q <= '0;
      rr_ptr <= 1'b0;
      hold_cnt <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
      disp_q <= IDLE_PATTERN;
      dp_q <= '0;
    end else begin
      state <= state_nxt;
      grant_q <= g_nxt;
      rr_ptr <= (fresh && (g_nxt[SRC_PRI] || g_nxt[SRC_SEC])) ? g_nxt[SRC_PRI] : rr_ptr;
      hold_cnt <= fresh ? '0 : (state == ST_HOLD && tick) ? hold_cnt + 16'd1 : hold_cnt;
      blink_cnt <= blink_wrap ? '0 : tick ? blink_cnt + 16'd1 : blink_cnt;
      blink_off <= off_nxt;
      disp_q <= (|(g_nxt & bus.blink_en) && off_nxt) ? BLINK_FILL : data_sel;
      dp_q <= (|(g_nxt & bus.blink_en) && off_nxt) ? 8'h00 : dp_sel;
    end
  end
endmodule
